// File: rtl/wb_slave_regfile_if.sv
// wb_slave_regfile_if: Wishbone classic-cycle bus bundle between one master and one register-file slave.
//   master drives: cyc, stb, we, addr (byte address), wdata, sel (byte lanes)
//   slave drives:  stall, ack, rdata, err
interface wb_slave_regfile_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                    cyc;
    logic                    stb;
    logic                    we;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] sel;
    logic                    stall;
    logic                    ack;
    logic [DATA_WIDTH-1:0]   rdata;
    logic                    err;
    modport master (output cyc, stb, we, addr, wdata, sel, input stall, ack, rdata, err);
    modport slave (input cyc, stb, we, addr, wdata, sel, output stall, ack, rdata, err);
endinterface

// File: rtl/wb_slave_regfile.sv
// wb_slave_regfile: Wishbone classic-cycle slave holding NUM_REGS registers, with programmable wait states,
// byte-lane writes and out-of-range address detection.
//   clk_i  : system clock, rising edge
//   rst_ni : asynchronous active-low reset
//   bus    : wb_slave_regfile_if.slave (cyc/stb/we/addr/wdata/sel in, stall/ack/rdata/err out)
// Optional macro WB_SLAVE_ERR_EN: out-of-range accesses complete with err instead of ack;
// when undefined err is tied low and every access completes with ack.
module wb_slave_regfile #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_REGS    = 16,
    parameter int WAIT_STATES = 0
) (
    input logic               clk_i,
    input logic               rst_ni,
    wb_slave_regfile_if.slave bus
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int OFF   = $clog2(BYTES);
    localparam int IW    = NUM_REGS > 1 ? $clog2(NUM_REGS) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP, DONE} state_t;

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d, word_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d, rdata_q;
    logic [BYTES-1:0]      sel_q, sel_d;
    logic [IW-1:0]         idx_d;
    logic                  oor_d, go_d, stall_q, ack_q;
    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];

    // The _d request fields are the live bus values on the accept edge and the latched
    // values afterwards, so the edge entering RESP always sees the right access.
    assign word_d = addr_d >> OFF;
    assign idx_d  = word_d[IW-1:0];
    assign oor_d  = word_d >= ADDR_WIDTH'(NUM_REGS);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        sel_d   = sel_q;
        go_d    = 1'b0;
        case (state_q)
            IDLE: if (bus.cyc && bus.stb) begin
                we_d    = bus.we;
                addr_d  = bus.addr;
                wdata_d = bus.wdata;
                sel_d   = bus.sel;
                if (WAIT_STATES == 0) begin
                    state_d = RESP;
                    go_d    = 1'b1;
                end else begin
                    cnt_d   = 4'(WAIT_STATES);
                    state_d = WAIT;
                end
            end
            // Abort wins over completion; stb and addr are ignored while waiting.
            WAIT: if (!bus.cyc) state_d = IDLE;
            else begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = RESP;
                    go_d    = 1'b1;
                end
            end
            RESP: state_d = DONE;
            // Wait for the master to drop the strobe so a held stb cannot start a second access.
            DONE: if (!(bus.cyc && bus.stb)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            sel_q   <= '0;
            stall_q <= 1'b0;
            ack_q   <= 1'b0;
            rdata_q <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            sel_q   <= sel_d;
            stall_q <= state_d != IDLE;
`ifdef WB_SLAVE_ERR_EN
            ack_q   <= go_d && !oor_d;
`else
            ack_q   <= go_d;
`endif
            if (go_d && !we_d) rdata_q <= oor_d ? '0 : regs_q[idx_d];
            if (go_d && we_d && !oor_d) begin
                for (int i = 0; i < BYTES; i++) begin
                    if (sel_d[i]) regs_q[idx_d][8*i +: 8] <= wdata_d[8*i +: 8];
                end
            end
        end
    end

`ifdef WB_SLAVE_ERR_EN
    logic err_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) err_q <= 1'b0;
        else err_q <= go_d && oor_d;
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

    assign bus.stall = stall_q;
    assign bus.ack   = ack_q;
    assign bus.rdata = rdata_q;
endmodule

// File: tb/tb_wb_slave_regfile.sv
// tb_wb_slave_regfile: drives three register-file slaves (0, 3 and 4 wait states) from one master and
// checks them against a per-instance register array model.
module tb_wb_slave_regfile;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [31:0] addr = '0, wdata = '0;
    logic [3:0]  sel = '0;
    int          dsel = 0;
    int          tests = 0, fails = 0;
    logic [2:0]  stall_v, ack_v, err_v;
    logic [31:0] rdata_v [3];
    logic [31:0] mdl [3][16];
    logic [31:0] last_rd [3];
    logic [31:0] rd;
    int          d;

`ifdef WB_SLAVE_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : gd
        wb_slave_regfile_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();
        assign bus.cyc   = cyc && dsel == g;
        assign bus.stb   = stb;
        assign bus.we    = we;
        assign bus.addr  = addr;
        assign bus.wdata = wdata;
        assign bus.sel   = sel;
        assign stall_v[g] = bus.stall;
        assign ack_v[g]   = bus.ack;
        assign err_v[g]   = bus.err;
        assign rdata_v[g] = bus.rdata;
        wb_slave_regfile #(
            .ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(16), .WAIT_STATES(g == 0 ? 0 : g + 2)
        ) dut (
            .clk_i(clk), .rst_ni(rst_n), .bus(bus)
        );
    end

    function automatic int ws_of(input int k);
        return k == 0 ? 0 : k + 2;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            last_rd[k] = '0;
            for (int i = 0; i < 16; i++) mdl[k][i] = '0;
        end
    endtask

    // One complete access; hold keeps cyc/stb up for an extra cycle after ack like the master's read task.
    task automatic access(input int k, input bit w, input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] s, input bit hold, output logic [31:0] r);
        bit          oor;
        logic [31:0] mask;
        oor  = (a >> 2) >= 32'd16;
        mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        @(negedge clk);
        dsel = k; cyc = 1'b1; stb = 1'b1; we = w; addr = a; wdata = wd; sel = s;
        @(posedge clk);
        for (int c = 0; c < ws_of(k); c++) begin
            @(negedge clk);
            chk("wait_stall", 32'(stall_v[k]), 32'd1);
            chk("wait_quiet", {30'd0, ack_v[k], err_v[k]}, 32'd0);
            stb = 1'($urandom); addr = $urandom; wdata = $urandom; sel = 4'($urandom);
        end
        @(negedge clk);
        if (w && !oor) mdl[k][4'(a >> 2)] = (mdl[k][4'(a >> 2)] & ~mask) | (wd & mask);
        if (!w) last_rd[k] = oor ? 32'd0 : mdl[k][4'(a >> 2)];
        chk("resp_ack", 32'(ack_v[k]), 32'(!(ERR_EN && oor)));
        chk("resp_err", 32'(err_v[k]), 32'(ERR_EN && oor));
        chk(w ? "resp_rdata_hold" : "resp_rdata", rdata_v[k], last_rd[k]);
        r = rdata_v[k];
        cyc = hold; stb = hold;
        @(negedge clk);
        chk("done_stall", 32'(stall_v[k]), 32'd1);
        chk("done_quiet", {30'd0, ack_v[k], err_v[k]}, 32'd0);
        if (hold) begin
            @(negedge clk);
            chk("hold_stall", 32'(stall_v[k]), 32'd1);
            chk("hold_single_ack", {30'd0, ack_v[k], err_v[k]}, 32'd0);
        end
        cyc = 1'b0; stb = 1'b0;
        @(negedge clk);
        chk("idle_state", {29'd0, stall_v[k], ack_v[k], err_v[k]}, 32'd0);
    endtask

    // Full-word write dropped by releasing cyc after n wait cycles; must leave no trace.
    task automatic abort_write(input int k, input logic [31:0] a, input logic [31:0] wd, input int n);
        @(negedge clk);
        dsel = k; cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = a; wdata = wd; sel = 4'hF;
        @(posedge clk);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            chk("abort_wait_stall", 32'(stall_v[k]), 32'd1);
        end
        cyc = 1'b0; stb = 1'b0;
        for (int c = 0; c < ws_of(k) + 2; c++) begin
            @(negedge clk);
            chk("abort_quiet", {29'd0, stall_v[k], ack_v[k], err_v[k]}, 32'd0);
        end
    endtask

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk("reset_stall", 32'(stall_v[k]), 32'd0);
            chk("reset_ack", 32'(ack_v[k]), 32'd0);
            chk("reset_err", 32'(err_v[k]), 32'd0);
            chk("reset_rdata", rdata_v[k], 32'd0);
        end
        rst_n = 1'b1;

        access(0, 1'b1, 32'h08, 32'hDEADBEEF, 4'hF, 1'b0, rd);
        access(0, 1'b0, 32'h08, 32'h0, 4'h0, 1'b0, rd);
        chk("t1_read", rd, 32'hDEADBEEF);

        access(0, 1'b1, 32'h00, 32'h11223344, 4'hF, 1'b0, rd);
        access(0, 1'b1, 32'h00, 32'hAABBCCDD, 4'h5, 1'b0, rd);
        access(0, 1'b0, 32'h00, 32'h0, 4'h0, 1'b1, rd);
        chk("t2_byte_lanes", rd, 32'h11BB33DD);

        access(1, 1'b1, 32'h04, 32'h5A5A5A5A, 4'hF, 1'b0, rd);
        access(1, 1'b0, 32'h04, 32'h0, 4'h0, 1'b1, rd);
        chk("t3_wait_read", rd, 32'h5A5A5A5A);

        access(0, 1'b1, 32'h40, 32'hFFFFFFFF, 4'hF, 1'b0, rd);
        access(0, 1'b0, 32'h40, 32'h0, 4'h0, 1'b1, rd);
        chk("t4_oor_read", rd, 32'h0);

        access(2, 1'b1, 32'h08, 32'hCAFEF00D, 4'hF, 1'b0, rd);
        abort_write(2, 32'h08, 32'h12345678, 2);
        access(2, 1'b0, 32'h08, 32'h0, 4'h0, 1'b0, rd);
        chk("t5_abort_kept", rd, 32'hCAFEF00D);

        access(2, 1'b1, 32'h0C, 32'hFFFF0000, 4'hF, 1'b0, rd);
        @(negedge clk);
        dsel = 2; cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = 32'h0C; wdata = 32'h77777777; sel = 4'hF;
        @(posedge clk);
        repeat (2) @(negedge clk);
        chk("t6_pre_reset_stall", 32'(stall_v[2]), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t6_reset_stall", 32'(stall_v[2]), 32'd0);
        chk("t6_reset_ack", 32'(ack_v[2]), 32'd0);
        chk("t6_reset_err", 32'(err_v[2]), 32'd0);
        chk("t6_reset_rdata", rdata_v[2], 32'd0);
        cyc = 1'b0; stb = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        access(2, 1'b0, 32'h0C, 32'h0, 4'h0, 1'b0, rd);
        chk("t6_reg3_cleared", rd, 32'h0);

        repeat (60) begin
            d = int'($urandom_range(0, 2));
            if (d > 0 && $urandom_range(0, 4) == 0)
                abort_write(d, 32'($urandom_range(0, 63)), $urandom, int'($urandom_range(1, ws_of(d) - 1)));
            else
                access(d, 1'($urandom), 32'($urandom_range(0, 79)), $urandom, 4'($urandom), 1'($urandom), rd);
        end

        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 16; i++) access(k, 1'b0, 32'(i * 4), 32'h0, 4'h0, 1'b0, rd);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/wb_slave_regfile.md
Name: wb_slave_regfile

Overview:
Wishbone classic-cycle responder: a bank of NUM_REGS data-wide registers on the slave side of the team's Wishbone interface. It is the target for the bench master's write_data/read_data tasks and for RTL masters in core_top. It adds programmable wait states, byte-lane writes and out-of-range address detection.

Parameters:
ADDR_WIDTH, 32, Wishbone address width in bits (byte address).
DATA_WIDTH, 32, data width in bits; must be a multiple of 8.
NUM_REGS, 16, number of registers; word index range is 0..NUM_REGS-1.
WAIT_STATES, 0, extra cycles inserted between accept and ack/err; legal range 0..15.

Ports:
clk  input  1  system clock; all logic on rising edge.
rst  input  1  asynchronous, active-low reset.
cyc  input  1  bus cycle valid.
stb  input  1  strobe; an access is requested when cyc&&stb.
we  input  1  1=write, 0=read.
addr  input  ADDR_WIDTH  byte address; word index = addr >> log2(DATA_WIDTH/8).
wdata  input  DATA_WIDTH  write data.
sel  input  DATA_WIDTH/8  byte-lane enables for writes.
stall  output  1  high while an access is in progress.
ack  output  1  single-cycle completion pulse.
rdata  output  DATA_WIDTH  read data; valid in the ack cycle.
err  output  1  single-cycle error pulse; used only when WB_SLAVE_ERR_EN is defined.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; stall=0, ack=0, err=0, rdata=0; all registers=0; wait counter=0.
- FSM states: IDLE, WAIT, RESP, DONE. All outputs are registered.
- IDLE: stall=0. At a rising edge where cyc&&stb=1, latch we/addr/wdata/sel and compute the index and the out-of-range flag (index>=NUM_REGS).
  - If WAIT_STATES=0, go to RESP.
  - Otherwise load the counter with WAIT_STATES and go to WAIT.
- WAIT: stall=1. Decrement the counter each cycle. Go to RESP on the edge where the counter reaches 1.
- Entering RESP (one edge):
  - In-range write: each register byte lane with sel[i]=1 takes wdata[8i+7:8i]; other lanes hold.
  - In-range read: rdata <= reg[index].
  - Out-of-range read: rdata <= 0.
  - Out-of-range write: no register changes.
  - ack (or err, see Optional Feature) is high for exactly the RESP cycle.
- Latency: ack is high in cycle 1+WAIT_STATES after the accept edge, i.e. the first cycle after accept when WAIT_STATES=0.
- RESP always goes to DONE. DONE: stall=1. It holds until it samples cyc&&stb=0, then goes to IDLE.
  - This guarantees exactly one ack per strobe.
  - The master's read task holds stb one extra cycle after ack; this must not start a second access.
- Abort: if cyc=0 is sampled in WAIT, go to IDLE, produce no ack/err and perform no register write. Aborts cannot occur in RESP or DONE.
- stb or addr changes during WAIT are ignored; the latched values are used.
- rdata holds its last value outside RESP. A write does not alter rdata.
- ack and err are never high simultaneously.
- Asynchronous reset mid-access: immediate return to the reset state. A pending write is discarded.
- Back-to-back accesses: minimum spacing is one accept per 3+WAIT_STATES cycles (accept, RESP, DONE with stb sampled low).

Optional Feature:
Macro WB_SLAVE_ERR_EN.
- Defined: an out-of-range access completes with err=1, ack=0 in the RESP cycle. Register and rdata effects are as above.
- Undefined: an out-of-range access completes with ack=1; err is tied to 0.
- In-range behaviour is identical in both builds.

Test Plan:
1. Reset release, WAIT_STATES=0: write addr 0x08 data 0xDEADBEEF, sel=0xF, then read 0x08 -> ack one cycle after each accept; read returns 0xDEADBEEF, err=0.
2. Byte lanes: reg0=0x11223344, write 0xAABBCCDD with sel=0x5, read -> 0x11BB33DD.
3. WAIT_STATES=3: read of reg1 (holding 0x5A5A5A5A) -> stall=1 for 3 cycles, ack in cycle 4 after accept, rdata=0x5A5A5A5A, exactly one ack while stb is held the extra cycle.
4. Out-of-range: write then read addr 0x40 with NUM_REGS=16 -> with WB_SLAVE_ERR_EN, err pulse, ack=0, rdata=0; without it, ack pulse, err=0, rdata=0; regs 0..15 unchanged.
5. Abort: WAIT_STATES=4, write 0x12345678 to reg2, drop cyc after 2 WAIT cycles -> no ack/err, reg2 retains its old value, next access is accepted normally.
6. Reset mid-access: pull rst low during WAIT of a write to reg3 -> stall/ack/err/rdata go to 0 immediately; after release reg3 reads 0x00000000.
